int_arbiter: RTL and testbench

- Collects up to NUM_SRC external interrupt lines, latches them as pending, and applies per-source enable and edge/level type.
- Selects one winner and drives it as a one-hot int_flag_o into the core's interrupt input, which feeds the interrupt controller.
- Claim/complete handshake with the core allows only one interrupt in service at a time (no nesting).
- Configured through a small CSR-style register port on the peripheral side.

---
 rtl/tinyriscv_pkg.sv | 18 +
 rtl/int_arb_pick.sv | 53 +++++
 rtl/int_arbiter.sv | 166 ++++++++++++++++
 tb/tb_int_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared core-side constants plus the interrupt arbiter's register map and state encoding.
package tinyriscv_pkg;

    localparam int                 INT_BUS  = 8;
    localparam logic [INT_BUS-1:0] INT_NONE = '0;

    localparam logic [1:0] INT_ARB_ENABLE  = 2'd0;
    localparam logic [1:0] INT_ARB_TYPE    = 2'd1;
    localparam logic [1:0] INT_ARB_PENDING = 2'd2;
    localparam logic [1:0] INT_ARB_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACTIVE
    } int_arb_state_e;

endpackage

// File: rtl/int_arb_pick.sv
// Combinational winner selection over the eligible vector.
// INT_ARB_RR_EN selects round-robin from rr_ptr_i; otherwise fixed priority, lowest index wins.
module int_arb_pick
    import tinyriscv_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] eligible_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    win_id_o,
    output logic               win_valid_o
);

`ifdef INT_ARB_RR_EN
    logic [NUM_SRC-1:0] rot;
    logic [ID_W:0]      sum;
    logic               found;

    // Rotate so bit 0 is the pointer position, then map the hit back to a source index.
    always_comb begin
        rot      = NUM_SRC'({eligible_i, eligible_i} >> rr_ptr_i);
        sum      = '0;
        found    = 1'b0;
        win_id_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr_i} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(NUM_SRC)) begin
                    sum = sum - (ID_W+1)'(NUM_SRC);
                end
                win_id_o = sum[ID_W-1:0];
            end
        end
        win_valid_o = found;
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr_i;

    always_comb begin
        win_id_o = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                win_id_o = ID_W'(i);
            end
        end
        win_valid_o = |eligible_i;
    end
`endif

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: latches pending sources, presents one winner to the core as a one-hot flag,
// and runs a single-level claim/complete handshake. INT_ARB_RR_EN enables round-robin selection.
module int_arbiter
    import tinyriscv_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic [INT_BUS-1:0] int_flag_o,
    input  logic               claim_i,
    input  logic               complete_i,
    output logic [ID_W-1:0]    claim_id_o
);

    int_arb_state_e     state_q, state_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] type_q, type_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] src_q;
    logic [ID_W-1:0]    winner_q, winner_d;
    logic [INT_BUS-1:0] flag_q, flag_d;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;

    logic [NUM_SRC-1:0] eligible, set_vec, clr_vec, claim_clr;
    logic [ID_W-1:0]    pick_id, rr_ptr;
    logic               pick_valid, claim_fire;
    logic               wr_enable, wr_type, wr_pending;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata_i;

    assign wr_enable  = cfg_we_i && (cfg_addr_i == INT_ARB_ENABLE);
    assign wr_type    = cfg_we_i && (cfg_addr_i == INT_ARB_TYPE);
    assign wr_pending = cfg_we_i && (cfg_addr_i == INT_ARB_PENDING);
    assign eligible   = pending_q & enable_q;
    assign claim_fire = (state_q == S_REQ) && claim_i;

    int_arb_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr),
        .win_id_o    (pick_id),
        .win_valid_o (pick_valid)
    );

`ifdef INT_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (claim_fire) begin
            rr_ptr_d = (winner_q == ID_W'(NUM_SRC - 1)) ? '0 : winner_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    // Set wins over W1C and claim clears, so a level source still high re-pends at once.
    always_comb begin
        set_vec   = (type_q & src_i & ~src_q) | (~type_q & src_i);
        clr_vec   = claim_clr | (wr_pending ? cfg_wdata_i[NUM_SRC-1:0] : '0);
        pending_d = (pending_q & ~clr_vec) | set_vec;
        enable_d  = wr_enable ? cfg_wdata_i[NUM_SRC-1:0] : enable_q;
        type_d    = wr_type   ? cfg_wdata_i[NUM_SRC-1:0] : type_q;
    end

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        flag_d     = flag_q;
        claim_id_d = claim_id_q;
        claim_clr  = '0;
        case (state_q)
            S_IDLE: begin
                flag_d = INT_NONE;
                if (pick_valid) begin
                    winner_d = pick_id;
                    flag_d   = INT_BUS'(1) << pick_id;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                // Claim acts on the winner the core was shown, ignoring same-cycle config writes.
                if (claim_i) begin
                    claim_id_d = winner_q;
                    claim_clr  = NUM_SRC'(1) << winner_q;
                    flag_d     = INT_NONE;
                    state_d    = S_ACTIVE;
                end else if (!pick_valid) begin
                    flag_d  = INT_NONE;
                    state_d = S_IDLE;
                end else begin
                    winner_d = pick_id;
                    flag_d   = INT_BUS'(1) << pick_id;
                end
            end
            S_ACTIVE: begin
                flag_d = INT_NONE;
                if (complete_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                flag_d  = INT_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            enable_q   <= '0;
            type_q     <= '0;
            pending_q  <= '0;
            src_q      <= '0;
            winner_q   <= '0;
            flag_q     <= INT_NONE;
            claim_id_q <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            type_q     <= type_d;
            pending_q  <= pending_d;
            src_q      <= src_i;
            winner_q   <= winner_d;
            flag_q     <= flag_d;
            claim_id_q <= claim_id_d;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            INT_ARB_ENABLE:  cfg_rdata_o = 32'(enable_q);
            INT_ARB_TYPE:    cfg_rdata_o = 32'(type_q);
            INT_ARB_PENDING: cfg_rdata_o = 32'(pending_q);
            INT_ARB_STATUS: begin
                cfg_rdata_o[31]       = (state_q == S_ACTIVE);
                cfg_rdata_o[ID_W-1:0] = claim_id_q;
            end
            default:         cfg_rdata_o = '0;
        endcase
    end

    assign int_flag_o = flag_q;
    assign claim_id_o = claim_id_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter; expectations are queued at stimulus time and popped at output time.
module tb_int_arbiter;
    import tinyriscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  src_i = '0;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic [31:0] cfg_rdata_o;
    logic [7:0]  int_flag_o;
    logic        claim_i = 1'b0;
    logic        complete_i = 1'b0;
    logic [2:0]  claim_id_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] rd;

    int_arbiter #(.NUM_SRC(8), .ID_W(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .src_i       (src_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_rdata_o (cfg_rdata_o),
        .int_flag_o  (int_flag_o),
        .claim_i     (claim_i),
        .complete_i  (complete_i),
        .claim_id_o  (claim_id_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        src_i = '0; claim_i = 0; complete_i = 0; cfg_we_i = 0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr_i = a;
        #1;
        d = cfg_rdata_o;
    endtask

    task automatic pulse_claim();
        claim_i = 1'b1; tick(); claim_i = 1'b0;
    endtask

    task automatic pulse_complete();
        complete_i = 1'b1; tick(); complete_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        exp_q.push_back(32'(INT_NONE));
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL reset_flag: got %h want %h", int_flag_o, exp_v); end
        exp_q.push_back(0);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(claim_id_o) !== exp_v) begin n_err++; $display("FAIL reset_id: got %0d want %0d", claim_id_o, exp_v); end
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(0);
            cfg_rd(2'(a), rd);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (rd !== exp_v) begin n_err++; $display("FAIL reset_reg%0d: got %h want %h", a, rd, exp_v); end
        end
    endtask

    task automatic test_single_edge();
        apply_reset();
        cfg_wr(INT_ARB_ENABLE, 32'h01);
        cfg_wr(INT_ARB_TYPE, 32'h01);
        repeat (3) tick();
        src_i[0] = 1'b1; exp_q.push_back(32'h00); exp_q.push_back(32'h01);
        tick();
        src_i[0] = 1'b0;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL edge_flag_n1: got %h want %h", int_flag_o, exp_v); end
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL edge_flag_n2: got %h want %h", int_flag_o, exp_v); end
        exp_q.push_back(32'h00); exp_q.push_back(32'h8000_0000);
        pulse_claim();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL edge_flag_claim: got %h want %h", int_flag_o, exp_v); end
        cfg_rd(INT_ARB_STATUS, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL edge_status_active: got %h want %h", rd, exp_v); end
        exp_q.push_back(32'h0);
        pulse_complete();
        cfg_rd(INT_ARB_STATUS, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL edge_status_done: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_priority();
        apply_reset();
        cfg_wr(INT_ARB_ENABLE, 32'hFF);
        cfg_wr(INT_ARB_TYPE, 32'hFF);
        src_i = 8'h24; exp_q.push_back(32'h04);
        tick(); src_i = '0; tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL prio_first: got %h want %h", int_flag_o, exp_v); end
        exp_q.push_back(2);
        pulse_claim();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(claim_id_o) !== exp_v) begin n_err++; $display("FAIL prio_id2: got %0d want %0d", claim_id_o, exp_v); end
        exp_q.push_back(32'h00); exp_q.push_back(32'h20);
        pulse_complete();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL prio_m1: got %h want %h", int_flag_o, exp_v); end
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL prio_m2: got %h want %h", int_flag_o, exp_v); end
        exp_q.push_back(5);
        pulse_claim();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(claim_id_o) !== exp_v) begin n_err++; $display("FAIL prio_id5: got %0d want %0d", claim_id_o, exp_v); end
        pulse_complete();
    endtask

    task automatic test_level();
        apply_reset();
        cfg_wr(INT_ARB_ENABLE, 32'h08);
        src_i[3] = 1'b1; exp_q.push_back(32'h08);
        tick(); tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL level_first: got %h want %h", int_flag_o, exp_v); end
        exp_q.push_back(3);
        pulse_claim();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(claim_id_o) !== exp_v) begin n_err++; $display("FAIL level_id: got %0d want %0d", claim_id_o, exp_v); end
        exp_q.push_back(32'h00); exp_q.push_back(32'h08);
        pulse_complete();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL level_m1: got %h want %h", int_flag_o, exp_v); end
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL level_repend: got %h want %h", int_flag_o, exp_v); end
        src_i[3] = 1'b0;
        cfg_wr(INT_ARB_PENDING, 32'h08);
        exp_q.push_back(32'h00); exp_q.push_back(32'h00);
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL level_cleared: got %h want %h", int_flag_o, exp_v); end
        cfg_rd(INT_ARB_PENDING, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL level_pending: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_masking();
        apply_reset();
        cfg_wr(INT_ARB_TYPE, 32'h02);
        src_i[1] = 1'b1; tick(); src_i[1] = 1'b0;
        exp_q.push_back(32'h00); exp_q.push_back(32'h02);
        tick(); tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL mask_flag: got %h want %h", int_flag_o, exp_v); end
        cfg_rd(INT_ARB_PENDING, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mask_pending: got %h want %h", rd, exp_v); end
        exp_q.push_back(32'h00); exp_q.push_back(32'h02);
        cfg_wr(INT_ARB_ENABLE, 32'h02);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL mask_en_m1: got %h want %h", int_flag_o, exp_v); end
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL mask_en_m2: got %h want %h", int_flag_o, exp_v); end
    endtask

    task automatic test_replace_ignore();
        apply_reset();
        cfg_wr(INT_ARB_ENABLE, 32'hFF);
        cfg_wr(INT_ARB_TYPE, 32'hFF);
        exp_q.push_back(32'h0);
        pulse_claim();
        cfg_rd(INT_ARB_STATUS, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL idle_claim_status: got %h want %h", rd, exp_v); end
        src_i[4] = 1'b1; tick(); src_i[4] = 1'b0;
        exp_q.push_back(32'h10);
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL repl_first: got %h want %h", int_flag_o, exp_v); end
        exp_q.push_back(32'h10); exp_q.push_back(32'h0);
        pulse_complete();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL req_complete_flag: got %h want %h", int_flag_o, exp_v); end
        cfg_rd(INT_ARB_STATUS, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL req_complete_status: got %h want %h", rd, exp_v); end
        src_i[0] = 1'b1; tick(); src_i[0] = 1'b0;
        exp_q.push_back(32'h01);
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL repl_second: got %h want %h", int_flag_o, exp_v); end
        // claim, complete and an ENABLE write all land together
        exp_q.push_back(32'h8000_0000);
        claim_i = 1'b1; complete_i = 1'b1;
        cfg_wr(INT_ARB_ENABLE, 32'h10);
        claim_i = 1'b0; complete_i = 1'b0;
        cfg_rd(INT_ARB_STATUS, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL both_pulse_status: got %h want %h", rd, exp_v); end
        exp_q.push_back(32'h10);
        pulse_complete();
        tick();
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL after_prewrite: got %h want %h", int_flag_o, exp_v); end
    endtask

    task automatic test_reset_active();
        apply_reset();
        cfg_wr(INT_ARB_ENABLE, 32'h04);
        cfg_wr(INT_ARB_TYPE, 32'h04);
        src_i[2] = 1'b1; tick(); src_i[2] = 1'b0;
        tick();
        exp_q.push_back(32'h8000_0002);
        pulse_claim();
        cfg_rd(INT_ARB_STATUS, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL ract_status_pre: got %h want %h", rd, exp_v); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL ract_flag: got %h want %h", int_flag_o, exp_v); end
        cfg_rd(INT_ARB_STATUS, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL ract_status: got %h want %h", rd, exp_v); end
        cfg_rd(INT_ARB_ENABLE, rd);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (rd !== exp_v) begin n_err++; $display("FAIL ract_enable: got %h want %h", rd, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (32'(claim_id_o) !== exp_v) begin n_err++; $display("FAIL ract_id: got %0d want %0d", claim_id_o, exp_v); end
    endtask

    task automatic test_rotation();
        logic [31:0] ids[3];
`ifdef INT_ARB_RR_EN
        ids = '{32'd1, 32'd6, 32'd1};
`else
        ids = '{32'd1, 32'd1, 32'd1};
`endif
        apply_reset();
        cfg_wr(INT_ARB_ENABLE, 32'h42);
        src_i = 8'h42;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h1 << ids[k]);
            exp_q.push_back(ids[k]);
            tick(); tick();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(int_flag_o) !== exp_v) begin n_err++; $display("FAIL rot_flag%0d: got %h want %h", k, int_flag_o, exp_v); end
            pulse_claim();
            exp_v = exp_q.pop_front(); n_cmp++;
            if (32'(claim_id_o) !== exp_v) begin n_err++; $display("FAIL rot_id%0d: got %0d want %0d", k, claim_id_o, exp_v); end
            complete_i = 1'b1;
        end
        complete_i = 1'b0;
        src_i = '0;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_level();
        test_masking();
        test_replace_ignore();
        test_reset_active();
        test_rotation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
